// File: rtl/chan_route_pkg.sv
// Shared defaults and helpers for the channel-routed FIFO block.
package chan_route_pkg;
    localparam int CR_N_CH  = 4;
    localparam int CR_W     = 8;
    localparam int CR_DEPTH = 4;

    // Address width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/chan_route_fifo_fifo.sv
// Single-channel synchronous FIFO: extra pointer MSB separates full from empty.
module chan_fifo
    import chan_route_pkg::*;
#(
    parameter int W     = CR_W,
    parameter int DEPTH = CR_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);
    localparam int AW = clog2_min1(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // Flush wins over any push or pop landing in the same cycle.
    assign do_push   = push & ~full & ~flush;
    assign do_pop    = pop & ~empty & ~flush;
    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/chan_route_fifo.sv
// Demux writes into N_CH channel FIFOs, mux reads from the channel picked by out_sel.
// Optional CHAN_ROUTE_FIFO_FLUSH_EN adds a per-channel flush port pair.
module chan_route_fifo
    import chan_route_pkg::*;
#(
    parameter  int N_CH  = CR_N_CH,
    parameter  int W     = CR_W,
    parameter  int DEPTH = CR_DEPTH,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef CHAN_ROUTE_FIFO_FLUSH_EN
    input  logic             flush,
    input  logic [SEL_W-1:0] flush_sel,
`endif
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    input  logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    input  logic             out_ready,
    output logic [N_CH-1:0]  empty,
    output logic [N_CH-1:0]  full
);
    localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

    logic                     in_ok, out_ok, in_fire, out_fire;
    logic [N_CH-1:0]          push_vec, pop_vec, flush_vec;
    logic [N_CH-1:0][W-1:0]   head_data;

    // Select range check guards non-power-of-2 channel counts.
    assign in_ok     = ({1'b0, in_sel} < N_CH_L);
    assign out_ok    = ({1'b0, out_sel} < N_CH_L);
    assign in_ready  = en & in_ok & ~full[in_sel];
    assign out_valid = en & out_ok & ~empty[out_sel];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = out_valid ? head_data[out_sel] : '0;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign push_vec[i] = in_fire && (in_sel == SEL_W'(i));
        assign pop_vec[i]  = out_fire && (out_sel == SEL_W'(i));
`ifdef CHAN_ROUTE_FIFO_FLUSH_EN
        assign flush_vec[i] = flush && (flush_sel == SEL_W'(i));
`else
        assign flush_vec[i] = 1'b0;
`endif
        chan_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_vec[i]),
            .pop       (pop_vec[i]),
            .flush     (flush_vec[i]),
            .din       (in_data),
            .head_data (head_data[i]),
            .empty     (empty[i]),
            .full      (full[i])
        );
    end
endmodule
